// File: rtl/byte_striping.sv
// rtl/byte_striping.sv - splits a 2f word stream into an aligned half-rate lane_0/lane_1 pair
// Optional STRIPE_STATS_EN: adds saturating per-lane valid word counters word_cnt_0/word_cnt_1.
module byte_striping #(
    parameter int DATA_W = 32
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] lane_0,
    output logic [DATA_W-1:0] lane_1,
    output logic              valid_0,
    output logic              valid_1,
    output logic              pair_stb,
    output logic              err_unbal
`ifdef STRIPE_STATS_EN
    ,
    output logic [15:0]       word_cnt_0,
    output logic [15:0]       word_cnt_1
`endif
);

    logic              r_sel;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_valid;
    logic [DATA_W-1:0] r_lane_0;
    logic [DATA_W-1:0] r_lane_1;
    logic              r_valid_0;
    logic              r_valid_1;
    logic              r_pair_stb;
    logic              r_err_unbal;
    logic [DATA_W-1:0] w_data_masked;

    // Invalid slots carry zeros so stale data never reaches a lane.
    assign w_data_masked = valid_in ? data_in : '0;

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_sel        <= 1'b0;
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_lane_0     <= '0;
            r_lane_1     <= '0;
            r_valid_0    <= 1'b0;
            r_valid_1    <= 1'b0;
            r_pair_stb   <= 1'b0;
            r_err_unbal  <= 1'b0;
        end else begin
            r_sel <= ~r_sel;
            if (!r_sel) begin
                r_hold_data  <= w_data_masked;
                r_hold_valid <= valid_in;
                r_pair_stb   <= 1'b0;
                r_err_unbal  <= 1'b0;
            end else begin
                r_lane_0    <= r_hold_data;
                r_valid_0   <= r_hold_valid;
                r_lane_1    <= w_data_masked;
                r_valid_1   <= valid_in;
                r_pair_stb  <= 1'b1;
                r_err_unbal <= r_hold_valid ^ valid_in;
            end
        end
    end

    assign lane_0    = r_lane_0;
    assign lane_1    = r_lane_1;
    assign valid_0   = r_valid_0;
    assign valid_1   = r_valid_1;
    assign pair_stb  = r_pair_stb;
    assign err_unbal = r_err_unbal;

`ifdef STRIPE_STATS_EN
    logic [15:0] r_word_cnt_0;
    logic [15:0] r_word_cnt_1;

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_word_cnt_0 <= '0;
            r_word_cnt_1 <= '0;
        end else if (r_sel) begin
            if (r_hold_valid && (r_word_cnt_0 != 16'hFFFF))
                r_word_cnt_0 <= r_word_cnt_0 + 16'd1;
            if (valid_in && (r_word_cnt_1 != 16'hFFFF))
                r_word_cnt_1 <= r_word_cnt_1 + 16'd1;
        end
    end

    assign word_cnt_0 = r_word_cnt_0;
    assign word_cnt_1 = r_word_cnt_1;
`endif

endmodule

// File: tb/tb_byte_striping.sv
// tb/tb_byte_striping.sv - self-checking bench for byte_striping
module tb_byte_striping;

    localparam int DATA_W = 32;

    logic              clk_2f = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic [DATA_W-1:0] lane_0;
    logic [DATA_W-1:0] lane_1;
    logic              valid_0;
    logic              valid_1;
    logic              pair_stb;
    logic              err_unbal;
`ifdef STRIPE_STATS_EN
    logic [15:0]       word_cnt_0;
    logic [15:0]       word_cnt_1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_2f = ~clk_2f;

    byte_striping #(.DATA_W(DATA_W)) dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .lane_0    (lane_0),
        .lane_1    (lane_1),
        .valid_0   (valid_0),
        .valid_1   (valid_1),
        .pair_stb  (pair_stb),
        .err_unbal (err_unbal)
`ifdef STRIPE_STATS_EN
        ,
        .word_cnt_0(word_cnt_0),
        .word_cnt_1(word_cnt_1)
`endif
    );

    typedef struct {
        logic              rst;
        logic              vin;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] e_l0;
        logic [DATA_W-1:0] e_l1;
        logic              e_v0;
        logic              e_v1;
        logic              e_stb;
        logic              e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic v, input logic [DATA_W-1:0] d);
        reset    = r;
        valid_in = v;
        data_in  = d;
        @(posedge clk_2f);
        #1;
    endtask

    function automatic vec_t mk(logic r, logic v, logic [31:0] d, logic [31:0] l0, logic [31:0] l1,
                                logic v0, logic v1, logic stb, logic err);
        vec_t x;
        x.rst = r; x.vin = v; x.din = d; x.e_l0 = l0; x.e_l1 = l1;
        x.e_v0 = v0; x.e_v1 = v1; x.e_stb = stb; x.e_err = err;
        return x;
    endfunction

    // Reference: a pair is formed from every two consecutive words accepted since reset.
    typedef struct { logic v; logic [DATA_W-1:0] d; } slot_t;
    slot_t             pend[$];
    slot_t             rt_in[$];
    logic [DATA_W-1:0] m_l0, m_l1;
    logic              m_v0, m_v1, m_stb, m_err;
    int                m_cnt0, m_cnt1;

    task automatic model_step(input logic r, input logic v, input logic [DATA_W-1:0] d);
        slot_t s;
        m_stb = 1'b0;
        m_err = 1'b0;
        if (r) begin
            pend.delete();
            rt_in.delete();
            m_l0 = '0; m_l1 = '0; m_v0 = 1'b0; m_v1 = 1'b0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            s.v = v;
            s.d = v ? d : '0;
            pend.push_back(s);
            rt_in.push_back(s);
            if (pend.size() == 2) begin
                m_l0 = pend[0].d; m_v0 = pend[0].v;
                m_l1 = pend[1].d; m_v1 = pend[1].v;
                m_stb = 1'b1;
                m_err = (pend[0].v != pend[1].v);
                if (m_v0 && m_cnt0 < 65535) m_cnt0++;
                if (m_v1 && m_cnt1 < 65535) m_cnt1++;
                pend.delete();
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;

        vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_00A0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_00A1, 32'hA0, 32'hA1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0000_00A2, 32'hA0, 32'hA1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_00A3, 32'hA2, 32'hA3, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h1234_5678, 32'hA2, 32'hA3, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0000_0000, 32'h1234_5678, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'hCAFE_0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 32'h0000_0055, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_00B0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_00B1, 32'hB0, 32'hB1, 1, 1, 1, 0));

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].vin, vecs[i].din);
            check($sformatf("vec%0d lane_0", i), 64'(lane_0), 64'(vecs[i].e_l0));
            check($sformatf("vec%0d lane_1", i), 64'(lane_1), 64'(vecs[i].e_l1));
            check($sformatf("vec%0d valids", i), 64'({valid_0, valid_1}), 64'({vecs[i].e_v0, vecs[i].e_v1}));
            check($sformatf("vec%0d pair_stb", i), 64'(pair_stb), 64'(vecs[i].e_stb));
            check($sformatf("vec%0d err_unbal", i), 64'(err_unbal), 64'(vecs[i].e_err));
        end

        // Randomized stream with occasional resets, plus a lane-merger round trip.
        model_step(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        for (int n = 0; n < 2000; n++) begin
            logic              r, v;
            logic [DATA_W-1:0] d;
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = DATA_W'($urandom);
            tick(r, v, d);
            model_step(r, v, d);
            check("rand lane_0", 64'(lane_0), 64'(m_l0));
            check("rand lane_1", 64'(lane_1), 64'(m_l1));
            check("rand valids", 64'({valid_0, valid_1}), 64'({m_v0, m_v1}));
            check("rand pair_stb", 64'(pair_stb), 64'(m_stb));
            check("rand err_unbal", 64'(err_unbal), 64'(m_err));
            if (pair_stb && rt_in.size() >= 2) begin
                check("merge slot0", 64'({valid_0, lane_0}), 64'({rt_in[0].v, rt_in[0].d}));
                check("merge slot1", 64'({valid_1, lane_1}), 64'({rt_in[1].v, rt_in[1].d}));
                void'(rt_in.pop_front());
                void'(rt_in.pop_front());
            end
`ifdef STRIPE_STATS_EN
            check("rand word_cnt_0", 64'(word_cnt_0), 64'(m_cnt0));
            check("rand word_cnt_1", 64'(word_cnt_1), 64'(m_cnt1));
`endif
        end

`ifdef STRIPE_STATS_EN
        tick(1'b1, 1'b0, '0);
        for (int n = 0; n < 20; n++) tick(1'b0, 1'b1, DATA_W'(n));
        check("stats cnt0 after 20", 64'(word_cnt_0), 64'd10);
        check("stats cnt1 after 20", 64'(word_cnt_1), 64'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
